// File: rtl/key_sd_ctrl_pkg.sv
// Shared types and command codes for the key command front-end.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    PRESS_FILT   = 2'b01,
    HELD         = 2'b10,
    RELEASE_FILT = 2'b11
  } key_state_t;

  localparam logic [1:0] CMD_NONE = 2'b00;
  localparam logic [1:0] CMD_S    = 2'b01;
  localparam logic [1:0] CMD_D    = 2'b10;

endpackage

// File: rtl/key_sd_ctrl_debounce.sv
// Per-key synchroniser, debounce FSM, debounced level and confirm strobe.
// Optional macro KEY_REPEAT_EN: re-raises the confirm strobe every
// REP_MAX+1 clocks while the key stays held.
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned CNT_MAX = 999_999,
  parameter int unsigned CNT_W   = 20,
  parameter int unsigned REP_MAX = 24_999_999
) (
  input  logic clk,
  input  logic rst,
  input  logic i_key,
  output logic o_level,
  output logic o_confirm
);

  logic             r_s1;
  logic             r_s2;
  logic [1:0]       r_settle;
  logic             r_blk;
  key_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             w_sync;
  logic             w_cnt_done;
  logic             w_confirm;

`ifdef KEY_REPEAT_EN
  localparam int unsigned REP_W = (REP_MAX > 0) ? $clog2(REP_MAX + 1) : 1;
  logic [REP_W-1:0] r_rep;
  logic             w_rep_done;
  assign w_rep_done = (r_rep == REP_W'(REP_MAX));
`endif

  assign w_sync     = r_s2;
  assign w_cnt_done = (r_cnt == CNT_W'(CNT_MAX));

  // Two-flop synchroniser plus the post-reset press blocker.
  // A key already down when reset hits stays ignored until it is seen
  // released; r_settle waits out the sync pipeline refilling after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1     <= 1'b1;
      r_s2     <= 1'b1;
      r_settle <= '0;
      r_blk    <= ~(r_s1 & r_s2);
    end else begin
      r_s1     <= i_key;
      r_s2     <= r_s1;
      r_settle <= {r_settle[0], 1'b1};
      if (r_blk && r_settle[1] && r_s2)
        r_blk <= 1'b0;
    end
  end

  // Debounce FSM: press/release windows of CNT_MAX+1 stable clocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_level <= 1'b1;
`ifdef KEY_REPEAT_EN
      r_rep   <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (!w_sync && !r_blk)
            r_state <= PRESS_FILT;
        end
        PRESS_FILT: begin
          if (w_sync) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (w_cnt_done) begin
            r_state <= HELD;
            r_cnt   <= '0;
            r_level <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        HELD: begin
          r_cnt <= '0;
          if (w_sync) begin
            r_state <= RELEASE_FILT;
`ifdef KEY_REPEAT_EN
            r_rep   <= '0;
          end else if (w_rep_done) begin
            r_rep <= '0;
          end else begin
            r_rep <= r_rep + 1'b1;
`endif
          end
        end
        RELEASE_FILT: begin
          if (!w_sync) begin
            r_state <= HELD;
            r_cnt   <= '0;
          end else if (w_cnt_done) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_level <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Confirm strobe decoded from current state so the top registers the
  // command on the same edge the FSM enters HELD.
  always_comb begin
    w_confirm = 1'b0;
    if (r_state == PRESS_FILT && !w_sync && w_cnt_done)
      w_confirm = 1'b1;
`ifdef KEY_REPEAT_EN
    if (r_state == HELD && !w_sync && w_rep_done)
      w_confirm = 1'b1;
`endif
  end

  assign o_level   = r_level;
  assign o_confirm = w_confirm;

endmodule

// File: rtl/key_sd_ctrl.sv
// Two-key command source: debounces both buttons and issues one-clock
// command pulses on flag_sd (key0 -> 01, key1 -> 10, key0 has priority).
// Optional macro KEY_REPEAT_EN: held keys auto-repeat their command.
module key_sd_ctrl
  import key_pkg::*;
#(
  parameter int unsigned CNT_MAX = 999_999,
  parameter int unsigned REP_MAX = 24_999_999,
  parameter int unsigned CNT_W   = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] key_in,
  output logic [1:0] flag_sd,
  output logic [1:0] key_level
);

  logic [1:0] w_confirm;
  logic [1:0] w_level;
  logic       r_pend;
  logic [1:0] r_flag;

  for (genvar g = 0; g < 2; g++) begin : g_key
    key_debounce #(
      .CNT_MAX (CNT_MAX),
      .CNT_W   (CNT_W),
      .REP_MAX (REP_MAX)
    ) u_deb (
      .clk       (clk),
      .rst       (rst),
      .i_key     (key_in[g]),
      .o_level   (w_level[g]),
      .o_confirm (w_confirm[g])
    );
  end

  // Priority encode confirms; a key1 confirm losing to key0 is deferred one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flag <= CMD_NONE;
      r_pend <= 1'b0;
    end else if (w_confirm[0]) begin
      r_flag <= CMD_S;
      if (w_confirm[1])
        r_pend <= 1'b1;
    end else if (w_confirm[1] || r_pend) begin
      r_flag <= CMD_D;
      r_pend <= 1'b0;
    end else begin
      r_flag <= CMD_NONE;
    end
  end

  assign flag_sd   = r_flag;
  assign key_level = w_level;

endmodule

// File: tb/tb_key_sd_ctrl.sv
// Directed bench for key_sd_ctrl with CNT_MAX=19, REP_MAX=49.
module tb_key_sd_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] key_in = 2'b11;
  logic [1:0] flag_sd;
  logic [1:0] key_level;

  int n_cmp = 0;
  int n_bad = 0;
  int n01 = 0;
  int n10 = 0;
  int n11 = 0;
  int b01, b10, b11;

  always #5 clk = ~clk;

  key_sd_ctrl #(
    .CNT_MAX (19),
    .REP_MAX (49),
    .CNT_W   (20)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .flag_sd   (flag_sd),
    .key_level (key_level)
  );

  // Pulse tally, sampled mid-cycle.
  always @(negedge clk) begin
    case (flag_sd)
      2'b01:   n01++;
      2'b10:   n10++;
      2'b11:   n11++;
      default: ;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // Reset
    rst = 1'b1; key_in = 2'b11;
    step(3);
    check_eq("rst_flag", 32'(flag_sd), 32'h0);
    check_eq("rst_level", 32'(key_level), 32'h3);
    rst = 1'b0;

    // T1: key0 press, pulse after edge 23
    b01 = n01;
    key_in = 2'b10;
    step(22);
    check_eq("t1_pre", 32'(flag_sd), 32'h0);
    step(1);
    check_eq("t1_pulse", 32'(flag_sd), 32'h1);
    check_eq("t1_level", 32'(key_level), 32'h2);
    step(1);
    check_eq("t1_after", 32'(flag_sd), 32'h0);
    step(20);
    check_eq("t1_count", 32'(n01 - b01), 32'd1);
    key_in = 2'b11;
    step(22);
    check_eq("t1_rel_pre", 32'(key_level), 32'h2);
    step(1);
    check_eq("t1_rel", 32'(key_level), 32'h3);
    step(5);

    // T2: key1 short burst, then real press
    b10 = n10;
    key_in = 2'b01;
    step(10);
    key_in = 2'b11;
    step(3);
    key_in = 2'b01;
    step(22);
    check_eq("t2_pre", 32'(flag_sd), 32'h0);
    check_eq("t2_nopulse", 32'(n10 - b10), 32'd0);
    step(1);
    check_eq("t2_pulse", 32'(flag_sd), 32'h2);
    step(1);
    check_eq("t2_after", 32'(flag_sd), 32'h0);
    step(10);
    check_eq("t2_count", 32'(n10 - b10), 32'd1);
    key_in = 2'b11;
    step(30);

    // T3: simultaneous press
    b01 = n01; b10 = n10; b11 = n11;
    key_in = 2'b00;
    step(23);
    check_eq("t3_first", 32'(flag_sd), 32'h1);
    step(1);
    check_eq("t3_second", 32'(flag_sd), 32'h2);
    step(1);
    check_eq("t3_after", 32'(flag_sd), 32'h0);
    check_eq("t3_level", 32'(key_level), 32'h0);
    step(5);
    check_eq("t3_n01", 32'(n01 - b01), 32'd1);
    check_eq("t3_n10", 32'(n10 - b10), 32'd1);
    check_eq("t3_n11", 32'(n11 - b11), 32'd0);
    key_in = 2'b11;
    step(30);

    // T4: long press, bouncy release
    b01 = n01;
    key_in = 2'b10;
    step(100);
    key_in = 2'b11; step(1);
    key_in = 2'b10; step(1);
    key_in = 2'b11; step(1);
    key_in = 2'b10; step(1);
    key_in = 2'b10; step(1);
    key_in = 2'b11;
    step(22);
    check_eq("t4_rel_pre", 32'(key_level), 32'h2);
    step(1);
    check_eq("t4_rel", 32'(key_level), 32'h3);
`ifdef KEY_REPEAT_EN
    check_eq("t4_count", 32'(n01 - b01), 32'd2);
`else
    check_eq("t4_count", 32'(n01 - b01), 32'd1);
`endif
    step(5);

    // T5: reset mid-press aborts it
    b01 = n01;
    key_in = 2'b10;
    step(14);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check_eq("t5_rst_flag", 32'(flag_sd), 32'h0);
    check_eq("t5_rst_level", 32'(key_level), 32'h3);
    step(60);
    check_eq("t5_count", 32'(n01 - b01), 32'd0);
    check_eq("t5_level", 32'(key_level), 32'h3);
    key_in = 2'b11;
    step(10);
    key_in = 2'b10;
    step(23);
    check_eq("t5_repress", 32'(flag_sd), 32'h1);
    key_in = 2'b11;
    step(30);

    // T6: long hold, auto-repeat when enabled
    b01 = n01;
    key_in = 2'b10;
    step(73);
`ifdef KEY_REPEAT_EN
    check_eq("t6_rep1", 32'(flag_sd), 32'h1);
`else
    check_eq("t6_rep1", 32'(flag_sd), 32'h0);
`endif
    step(127);
`ifdef KEY_REPEAT_EN
    check_eq("t6_count", 32'(n01 - b01), 32'd4);
`else
    check_eq("t6_count", 32'(n01 - b01), 32'd1);
`endif
    key_in = 2'b11;
    step(30);
    check_eq("end_level", 32'(key_level), 32'h3);
    check_eq("end_n11", 32'(n11), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
